// File: rtl/blink_rtc.sv
// Real-time clock: programmable tick prescaler, tick/second/minute cascade, masked interrupt status.
// Latency: register writes and reads take effect on the strobe edge; rtc_int is decoded from registers.
// Backpressure: none; single-cycle I/O strobes are always accepted.
module blink_rtc #(
    parameter int TICK_DIV      = 49152,
    parameter int TICKS_PER_SEC = 200,
    parameter int MIN_WIDTH     = 21
) (
    input  logic       mck,
    input  logic       rin_n,
    input  logic       rtc_rst,
    input  logic [7:0] io_addr,
    input  logic [7:0] io_wdata,
    input  logic       io_wr,
    input  logic       io_rd,
    output logic [7:0] io_rdata,
    output logic [2:0] tsta,
    output logic [2:0] tmk,
    output logic       rtc_int,
    output logic       tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]    T0_LAST  = 8'(TICKS_PER_SEC - 1);

    localparam logic [7:0] A_TACK = 8'hB4;
    localparam logic [7:0] A_TMK  = 8'hB5;
    localparam logic [7:0] A_TIM0 = 8'hD0;
    localparam logic [7:0] A_SH1  = 8'hD1;
    localparam logic [7:0] A_SHM0 = 8'hD2;
    localparam logic [7:0] A_SHM1 = 8'hD3;
    localparam logic [7:0] A_SHM2 = 8'hD4;

    logic [PW-1:0]        pre_q,  pre_d;
    logic [7:0]           tim0_q, tim0_d;
    logic [5:0]           tim1_q, tim1_d;
    logic [MIN_WIDTH-1:0] timm_q, timm_d;
    logic [5:0]           sh1_q,  sh1_d;
    logic [MIN_WIDTH-1:0] shm_q,  shm_d;
    logic [2:0]           tsta_q, tsta_d;
    logic [2:0]           tmk_q,  tmk_d;
    logic [7:0]           rdata_q, rdata_d;
    logic                 tick_q;

    logic       wrap, sec_roll, min_roll, rd_tim0;
    logic [2:0] tack;
    logic [23:0] shm_ext;
    logic       unused_wdata;

    assign unused_wdata = ^io_wdata[7:3];
    assign shm_ext      = 24'(shm_q);

    always_comb begin
        wrap     = !rtc_rst && (pre_q == PRE_LAST);
        sec_roll = wrap && (tim0_q == T0_LAST);
        min_roll = sec_roll && (tim1_q == 6'd59);
        rd_tim0  = io_rd && (io_addr == A_TIM0);

        pre_d  = pre_q;
        tim0_d = tim0_q;
        tim1_d = tim1_q;
        timm_d = timm_q;
        sh1_d  = sh1_q;
        shm_d  = shm_q;
        if (rtc_rst) begin
            pre_d  = '0;
            tim0_d = '0;
            tim1_d = '0;
            timm_d = '0;
            sh1_d  = '0;
            shm_d  = '0;
        end else begin
            pre_d = wrap ? '0 : pre_q + 1'b1;
            if (sec_roll)  tim0_d = '0;
            else if (wrap) tim0_d = tim0_q + 8'd1;
            if (min_roll)      tim1_d = '0;
            else if (sec_roll) tim1_d = tim1_q + 6'd1;
            if (min_roll)  timm_d = timm_q + 1'b1;
            // Snapshot uses pre-edge counters so a read racing a wrap stays self-consistent
            if (rd_tim0) begin
                sh1_d = tim1_q;
                shm_d = timm_q;
            end
        end

        tack   = (io_wr && io_addr == A_TACK) ? io_wdata[2:0] : 3'b000;
        tsta_d = (tsta_q & ~tack) | {min_roll, sec_roll, wrap};
        tmk_d  = (io_wr && io_addr == A_TMK) ? io_wdata[2:0] : tmk_q;

        rdata_d = rdata_q;
        if (io_rd) begin
            case (io_addr)
                A_TMK:   rdata_d = {5'b0, tsta_q};
                A_TIM0:  rdata_d = tim0_q;
                A_SH1:   rdata_d = {2'b0, sh1_q};
                A_SHM0:  rdata_d = shm_ext[7:0];
                A_SHM1:  rdata_d = shm_ext[15:8];
                A_SHM2:  rdata_d = shm_ext[23:16];
                default: rdata_d = rdata_q;
            endcase
        end
    end

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            pre_q   <= '0;
            tim0_q  <= '0;
            tim1_q  <= '0;
            timm_q  <= '0;
            sh1_q   <= '0;
            shm_q   <= '0;
            tsta_q  <= '0;
            tmk_q   <= '0;
            rdata_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            tim0_q  <= tim0_d;
            tim1_q  <= tim1_d;
            timm_q  <= timm_d;
            sh1_q   <= sh1_d;
            shm_q   <= shm_d;
            tsta_q  <= tsta_d;
            tmk_q   <= tmk_d;
            rdata_q <= rdata_d;
            tick_q  <= wrap;
        end
    end

    assign io_rdata = rdata_q;
    assign tsta     = tsta_q;
    assign tmk      = tmk_q;
    assign tick     = tick_q;
    assign rtc_int  = |(tsta_q & tmk_q);

endmodule

// File: tb/tb_blink_rtc.sv
// Randomised and directed stimulus against an arithmetic reference model, checked through a scoreboard queue.
module tb_blink_rtc;

    localparam int TD  = 4;
    localparam int TPS = 3;
    localparam int MW  = 4;

    logic       mck = 1'b0;
    logic       rin_n = 1'b0;
    logic       rtc_rst = 1'b0;
    logic [7:0] io_addr = 8'h00;
    logic [7:0] io_wdata = 8'h00;
    logic       io_wr = 1'b0;
    logic       io_rd = 1'b0;
    logic [7:0] io_rdata;
    logic [2:0] tsta;
    logic [2:0] tmk;
    logic       rtc_int;
    logic       tick;

    blink_rtc #(.TICK_DIV(TD), .TICKS_PER_SEC(TPS), .MIN_WIDTH(MW)) dut (
        .mck(mck), .rin_n(rin_n), .rtc_rst(rtc_rst),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_wr(io_wr), .io_rd(io_rd),
        .io_rdata(io_rdata), .tsta(tsta), .tmk(tmk), .rtc_int(rtc_int), .tick(tick)
    );

    always #5 mck = ~mck;

    typedef struct {
        int tick;
        int tsta;
        int tmk;
        int rint;
        int rd;
        int rdata;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // Reference state: edges counted since the counters last restarted
    int cnt = 0;
    int tsta_m = 0, tmk_m = 0, rdata_m = 0, sh1_m = 0, shm_m = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: every posedge computes the architectural result of that edge
    initial forever begin
        exp_t e;
        int c, w, t0, t1, tm, wrap, sroll, mroll, tack;
        @(posedge mck);
        if (!rin_n) begin
            cnt = 0; tsta_m = 0; tmk_m = 0; rdata_m = 0; sh1_m = 0; shm_m = 0;
            e = '{0, 0, 0, 0, 0, 0};
        end else begin
            c  = cnt;
            w  = c / TD;
            t0 = w % TPS;
            t1 = (w / TPS) % 60;
            tm = (w / (TPS * 60)) % (1 << MW);
            wrap  = (!rtc_rst && (c % TD == TD - 1)) ? 1 : 0;
            sroll = (wrap == 1 && t0 == TPS - 1) ? 1 : 0;
            mroll = (sroll == 1 && t1 == 59) ? 1 : 0;
            if (io_rd) begin
                case (io_addr)
                    8'hB5: rdata_m = tsta_m;
                    8'hD0: rdata_m = t0;
                    8'hD1: rdata_m = sh1_m;
                    8'hD2: rdata_m = shm_m & 255;
                    8'hD3: rdata_m = (shm_m >> 8) & 255;
                    8'hD4: rdata_m = (shm_m >> 16) & 255;
                    default: ;
                endcase
            end
            if (rtc_rst) begin
                sh1_m = 0; shm_m = 0;
            end else if (io_rd && io_addr == 8'hD0) begin
                sh1_m = t1; shm_m = tm;
            end
            tack = (io_wr && io_addr == 8'hB4) ? int'(io_wdata) & 7 : 0;
            if (io_wr && io_addr == 8'hB5) tmk_m = int'(io_wdata) & 7;
            tsta_m = (tsta_m & ~tack & 7) | (mroll << 2) | (sroll << 1) | wrap;
            cnt = rtc_rst ? 0 : c + 1;
            e.tick  = wrap;
            e.tsta  = tsta_m;
            e.tmk   = tmk_m;
            e.rint  = ((tsta_m & tmk_m) != 0) ? 1 : 0;
            e.rd    = io_rd ? 1 : 0;
            e.rdata = rdata_m;
        end
        exp_q.push_back(e);
    end

    // Monitor: pops one expectation per cycle, compares away from the active edge
    initial forever begin
        exp_t e;
        @(negedge mck);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tick", int'(tick), e.tick);
            chk("tsta", int'(tsta), e.tsta);
            chk("tmk", int'(tmk), e.tmk);
            chk("rtc_int", int'(rtc_int), e.rint);
            if (e.rd == 1) chk("io_rdata", int'(io_rdata), e.rdata);
        end
    end

    task automatic step(input bit rr, input bit rd, input bit wr,
                        input logic [7:0] addr, input logic [7:0] wd);
        @(negedge mck);
        rtc_rst = rr; io_rd = rd; io_wr = wr; io_addr = addr; io_wdata = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // mode 0: next edge wraps; 1: next edge does not wrap; 2: next edge is a second rollover
    task automatic step_when(input int mode, input bit rd, input bit wr,
                             input logic [7:0] addr, input logic [7:0] wd);
        bit found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            bit hit;
            @(negedge mck);
            case (mode)
                0:       hit = (cnt % TD == TD - 1);
                1:       hit = (cnt % TD != TD - 1);
                default: hit = (cnt % TD == TD - 1) && ((cnt / TD) % TPS == TPS - 1);
            endcase
            rtc_rst = 1'b0;
            if (hit) begin
                io_rd = rd; io_wr = wr; io_addr = addr; io_wdata = wd;
                found = 1'b1;
            end else begin
                io_rd = 1'b0; io_wr = 1'b0;
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL step_when_timeout mode=%0d actual=timeout required=aligned edge", mode);
        end
    endtask

    logic [7:0] raddr [7] = '{8'hB5, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'h3C};

    initial begin
        int hold;
        repeat (3) @(posedge mck);
        @(negedge mck);
        rin_n = 1'b1;

        // Tick period and first second rollover, then readback of counters and status
        idle(12);
        step(0, 1, 0, 8'hD0, 8'h00);
        step(0, 1, 0, 8'hD1, 8'h00);
        step(0, 1, 0, 8'hB5, 8'h00);

        // Run to the minute counter wrap (16 minutes) and read it back
        idle(60 * TPS * TD * 16);
        step(0, 1, 0, 8'hD0, 8'h00);
        step(0, 1, 0, 8'hD2, 8'h00);
        step(0, 1, 0, 8'hD3, 8'h00);

        // Mask, interrupt, set-over-clear
        step_when(1, 0, 1, 8'hB4, 8'h07);
        step(0, 0, 1, 8'hB5, 8'h01);
        idle(6);
        step_when(1, 0, 1, 8'hB4, 8'h01);
        idle(1);
        step_when(2, 0, 1, 8'hB4, 8'h07);
        idle(2);

        // Coherent snapshot across a second rollover
        step_when(2, 1, 0, 8'hD0, 8'h00);
        step(0, 1, 0, 8'hD1, 8'h00);
        step(0, 1, 0, 8'hD2, 8'h00);

        // Synchronous counter clear mid-count
        step(0, 0, 1, 8'hB5, 8'h05);
        idle(2);
        for (int i = 0; i < 10; i++)
            step(1, (i == 5), 0, (i == 5) ? 8'hD0 : 8'hD1, 8'h00);
        idle(8);
        step(0, 1, 0, 8'hD0, 8'h00);

        // Randomised traffic
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit rr;
            r = $urandom_range(0, 99);
            if (hold == 0 && $urandom_range(0, 199) == 0) hold = $urandom_range(1, 6);
            rr = (hold > 0);
            if (hold > 0) hold--;
            if (r < 15)      step(rr, 1, 0, raddr[$urandom_range(0, 6)], 8'h00);
            else if (r < 21) step(rr, 0, 1, 8'hB4, 8'($urandom_range(0, 255)));
            else if (r < 24) step(rr, 0, 1, 8'hB5, 8'($urandom_range(0, 255)));
            else if (r < 26) step(rr, 0, 1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            else             step(rr, 0, 0, 8'($urandom_range(0, 255)), 8'h00);
        end

        // Asynchronous reset between edges
        step(0, 0, 1, 8'hB5, 8'h07);
        idle(6);
        step(0, 1, 0, 8'hB5, 8'h00);
        idle(1);
        @(negedge mck);
        #2 rin_n = 1'b0;
        #1;
        chk("async_rdata", int'(io_rdata), 0);
        chk("async_tsta", int'(tsta), 0);
        chk("async_tmk", int'(tmk), 0);
        chk("async_int", int'(rtc_int), 0);
        chk("async_tick", int'(tick), 0);
        repeat (2) @(negedge mck);
        rin_n = 1'b1;
        idle(10);
        step(0, 1, 0, 8'hD0, 8'h00);

        idle(1);
        @(negedge mck);
        #1;
        chk("queue_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
